// File: rtl/vlsu_req_issuer_if.sv
// Signal bundle around vlsu_req_issuer: sequencer request side, VLSU request port,
// VLSU completion responses and status outputs.
interface vlsu_req_issuer_if #(
  parameter int unsigned NrIds    = 32'd8,
  parameter int unsigned PayloadW = 32'd128
);
  localparam int unsigned IdW  = $clog2(NrIds);
  localparam int unsigned CntW = $clog2(NrIds + 32'd1);

  logic                seq_valid_i;
  logic                seq_ready_o;
  logic                seq_is_load_i;
  logic [PayloadW-1:0] seq_payload_i;
  logic                pe_req_valid_o;
  logic                pe_req_ready_i;
  logic [IdW-1:0]      pe_req_id_o;
  logic                pe_req_is_load_o;
  logic [PayloadW-1:0] pe_req_payload_o;
  logic                ld_done_valid_i;
  logic [IdW-1:0]      ld_done_id_i;
  logic                st_done_valid_i;
  logic [IdW-1:0]      st_done_id_i;
  logic [CntW-1:0]     ld_cnt_o;
  logic [CntW-1:0]     st_cnt_o;
  logic                idle_o;
  logic                err_o;

  // Issuer view: consumes sequencer requests and completions, drives the VLSU request.
  modport master (
    input  seq_valid_i, seq_is_load_i, seq_payload_i, pe_req_ready_i,
           ld_done_valid_i, ld_done_id_i, st_done_valid_i, st_done_id_i,
    output seq_ready_o, pe_req_valid_o, pe_req_id_o, pe_req_is_load_o, pe_req_payload_o,
           ld_cnt_o, st_cnt_o, idle_o, err_o
  );

  // Environment view: sequencer plus VLSU.
  modport slave (
    output seq_valid_i, seq_is_load_i, seq_payload_i, pe_req_ready_i,
           ld_done_valid_i, ld_done_id_i, st_done_valid_i, st_done_id_i,
    input  seq_ready_o, pe_req_valid_o, pe_req_id_o, pe_req_is_load_o, pe_req_payload_o,
           ld_cnt_o, st_cnt_o, idle_o, err_o
  );
endinterface

// File: rtl/vlsu_req_issuer.sv
// Admits vector load/store requests, tags them with round-robin reqIds, presents them on a
// registered VLSU request port and tracks outstanding IDs until the VLSU reports completion.
module vlsu_req_issuer #(
  parameter int unsigned NrIds       = 32'd8,
  parameter int unsigned PayloadW    = 32'd128,
  parameter int unsigned MaxLoads    = 32'd4,
  parameter int unsigned MaxStores   = 32'd4,
  parameter bit          StrictOrder = 1'b1
) (
  input logic              clk_i,
  input logic              rst_i,
  vlsu_req_issuer_if.master bus
);
  localparam int unsigned IdW  = $clog2(NrIds);
  localparam int unsigned CntW = $clog2(NrIds + 32'd1);

  logic                valid_r;
  logic [IdW-1:0]      id_r;
  logic                is_load_r;
  logic [PayloadW-1:0] payload_r;
  logic [IdW-1:0]      next_id_r;
  logic [NrIds-1:0]    sb_r;
  logic [NrIds-1:0]    type_r;
  logic [CntW-1:0]     ld_cnt_r;
  logic [CntW-1:0]     st_cnt_r;
  logic                err_r;

  logic free_slot_s;
  logic ld_room_s;
  logic st_room_s;
  logic type_ok_s;
  logic ready_s;
  logic accept_s;
  logic ld_inc_s;
  logic st_inc_s;
  logic ld_ok_s;
  logic st_ok_s;
  logic proto_err_s;

  // Admission and completion qualification, all from registered state plus current inputs.
  always_comb begin
    free_slot_s = !valid_r || bus.pe_req_ready_i;
    ld_room_s   = (ld_cnt_r < CntW'(MaxLoads)) && (!StrictOrder || (st_cnt_r == '0));
    st_room_s   = (st_cnt_r < CntW'(MaxStores)) && (!StrictOrder || (ld_cnt_r == '0));
    if (bus.seq_is_load_i) begin
      type_ok_s = ld_room_s;
    end else begin
      type_ok_s = st_room_s;
    end
    // In-order allocation: a busy next_id stalls issue rather than skipping ahead.
    ready_s     = free_slot_s && !sb_r[next_id_r] && type_ok_s;
    accept_s    = bus.seq_valid_i && ready_s;
    ld_inc_s    = accept_s && bus.seq_is_load_i;
    st_inc_s    = accept_s && !bus.seq_is_load_i;
    ld_ok_s     = bus.ld_done_valid_i && sb_r[bus.ld_done_id_i] && type_r[bus.ld_done_id_i];
    st_ok_s     = bus.st_done_valid_i && sb_r[bus.st_done_id_i] && !type_r[bus.st_done_id_i];
    proto_err_s = (bus.ld_done_valid_i && !ld_ok_s) || (bus.st_done_valid_i && !st_ok_s);
  end

  // Output request register, reqId allocation and sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r   <= 1'b0;
      id_r      <= '0;
      is_load_r <= 1'b0;
      payload_r <= '0;
      next_id_r <= '0;
      err_r     <= 1'b0;
    end else begin
      if (free_slot_s) begin
        valid_r <= accept_s;
        if (accept_s) begin
          id_r      <= next_id_r;
          is_load_r <= bus.seq_is_load_i;
          payload_r <= bus.seq_payload_i;
          next_id_r <= next_id_r + IdW'(1);
        end
      end
      if (proto_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Scoreboard, type table and in-flight counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_r     <= '0;
      type_r   <= '0;
      ld_cnt_r <= '0;
      st_cnt_r <= '0;
    end else begin
      // Accept and a valid completion can never target the same ID: accept needs the bit clear.
      if (accept_s) begin
        sb_r[next_id_r]   <= 1'b1;
        type_r[next_id_r] <= bus.seq_is_load_i;
      end
      if (ld_ok_s) begin
        sb_r[bus.ld_done_id_i] <= 1'b0;
      end
      if (st_ok_s) begin
        sb_r[bus.st_done_id_i] <= 1'b0;
      end
      ld_cnt_r <= ld_cnt_r + CntW'(ld_inc_s) - CntW'(ld_ok_s);
      st_cnt_r <= st_cnt_r + CntW'(st_inc_s) - CntW'(st_ok_s);
    end
  end

  assign bus.seq_ready_o      = ready_s;
  assign bus.pe_req_valid_o   = valid_r;
  assign bus.pe_req_id_o      = id_r;
  assign bus.pe_req_is_load_o = is_load_r;
  assign bus.pe_req_payload_o = payload_r;
  assign bus.ld_cnt_o         = ld_cnt_r;
  assign bus.st_cnt_o         = st_cnt_r;
  assign bus.idle_o           = !valid_r && (ld_cnt_r == '0) && (st_cnt_r == '0);
  assign bus.err_o            = err_r;

endmodule

// File: tb/tb_vlsu_req_issuer.sv
// Directed self-checking bench for vlsu_req_issuer with default parameters
// (NrIds 8, MaxLoads 4, MaxStores 4, StrictOrder 1).
module tb_vlsu_req_issuer;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  vlsu_req_issuer_if #(.NrIds(32'd8), .PayloadW(32'd128)) bus ();

  vlsu_req_issuer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and registered outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet_inputs();
    bus.seq_valid_i     = 1'b0;
    bus.seq_is_load_i   = 1'b1;
    bus.seq_payload_i   = '0;
    bus.pe_req_ready_i  = 1'b1;
    bus.ld_done_valid_i = 1'b0;
    bus.ld_done_id_i    = '0;
    bus.st_done_valid_i = 1'b0;
    bus.st_done_id_i    = '0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.seq_is_load_i = 1'b1;
    settle();
    n_tests++; if (bus.pe_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d want 0", bus.pe_req_valid_o); end
    n_tests++; if (bus.pe_req_id_o !== 3'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", bus.pe_req_id_o); end
    n_tests++; if (bus.pe_req_is_load_o !== 1'b0) begin n_fail++; $display("FAIL reset_is_load: got %0d want 0", bus.pe_req_is_load_o); end
    n_tests++; if (bus.pe_req_payload_o !== 128'd0) begin n_fail++; $display("FAIL reset_payload: got %h want 0", bus.pe_req_payload_o); end
    n_tests++; if (bus.ld_cnt_o !== 4'd0 || bus.st_cnt_o !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got ld %0d st %0d want 0 0", bus.ld_cnt_o, bus.st_cnt_o); end
    n_tests++; if (bus.idle_o !== 1'b1 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_err: got idle %0d err %0d want 1 0", bus.idle_o, bus.err_o); end
    n_tests++; if (bus.seq_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0d want 1", bus.seq_ready_o); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_pl;
    do_reset();
    bus.seq_valid_i   = 1'b1;
    bus.seq_is_load_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.seq_payload_i = {32'hA5A5_0000 + 32'(i), 96'h0};
      exp_pl = {32'hA5A5_0000 + 32'(i), 96'h0};
      step();
      if (i == 2) bus.seq_valid_i = 1'b0;
      n_tests++; if (bus.pe_req_valid_o !== 1'b1 || bus.pe_req_id_o !== 3'(i)) begin n_fail++; $display("FAIL b2b_id%0d: got valid %0d id %0d want 1 %0d", i, bus.pe_req_valid_o, bus.pe_req_id_o, i); end
      n_tests++; if (bus.pe_req_payload_o !== exp_pl || bus.pe_req_is_load_o !== 1'b1) begin n_fail++; $display("FAIL b2b_payload%0d: got %h want %h", i, bus.pe_req_payload_o, exp_pl); end
    end
    n_tests++; if (bus.ld_cnt_o !== 4'd3 || bus.idle_o !== 1'b0) begin n_fail++; $display("FAIL b2b_cnt: got ld %0d idle %0d want 3 0", bus.ld_cnt_o, bus.idle_o); end
    step();
    n_tests++; if (bus.pe_req_valid_o !== 1'b0 || bus.ld_cnt_o !== 4'd3) begin n_fail++; $display("FAIL b2b_drain: got valid %0d ld %0d want 0 3", bus.pe_req_valid_o, bus.ld_cnt_o); end
  endtask

  task automatic test_max_loads();
    do_reset();
    bus.seq_valid_i   = 1'b1;
    bus.seq_is_load_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
    end
    settle();
    n_tests++; if (bus.seq_ready_o !== 1'b0 || bus.ld_cnt_o !== 4'd4) begin n_fail++; $display("FAIL maxld_full: got ready %0d ld %0d want 0 4", bus.seq_ready_o, bus.ld_cnt_o); end
    step();
    n_tests++; if (bus.pe_req_valid_o !== 1'b0 || bus.ld_cnt_o !== 4'd4) begin n_fail++; $display("FAIL maxld_held: got valid %0d ld %0d want 0 4", bus.pe_req_valid_o, bus.ld_cnt_o); end
    bus.ld_done_valid_i = 1'b1;
    bus.ld_done_id_i    = 3'd1;
    settle();
    n_tests++; if (bus.seq_ready_o !== 1'b0) begin n_fail++; $display("FAIL maxld_done_cycle: got ready %0d want 0", bus.seq_ready_o); end
    step();
    bus.ld_done_valid_i = 1'b0;
    settle();
    n_tests++; if (bus.seq_ready_o !== 1'b1 || bus.ld_cnt_o !== 4'd3) begin n_fail++; $display("FAIL maxld_freed: got ready %0d ld %0d want 1 3", bus.seq_ready_o, bus.ld_cnt_o); end
    step();
    bus.seq_valid_i = 1'b0;
    n_tests++; if (bus.pe_req_valid_o !== 1'b1 || bus.pe_req_id_o !== 3'd4 || bus.ld_cnt_o !== 4'd4) begin n_fail++; $display("FAIL maxld_fifth: got valid %0d id %0d ld %0d want 1 4 4", bus.pe_req_valid_o, bus.pe_req_id_o, bus.ld_cnt_o); end
  endtask

  task automatic test_strict_order();
    do_reset();
    bus.seq_valid_i   = 1'b1;
    bus.seq_is_load_i = 1'b1;
    step();
    bus.seq_is_load_i = 1'b0;
    bus.seq_payload_i = 128'h5700_0000_0000_0000_0000_0000_0000_0001;
    settle();
    n_tests++; if (bus.seq_ready_o !== 1'b0) begin n_fail++; $display("FAIL strict_block: got ready %0d want 0", bus.seq_ready_o); end
    step();
    n_tests++; if (bus.st_cnt_o !== 4'd0 || bus.pe_req_valid_o !== 1'b0 || bus.seq_ready_o !== 1'b0) begin n_fail++; $display("FAIL strict_wait: got st %0d valid %0d ready %0d want 0 0 0", bus.st_cnt_o, bus.pe_req_valid_o, bus.seq_ready_o); end
    bus.ld_done_valid_i = 1'b1;
    bus.ld_done_id_i    = 3'd0;
    settle();
    n_tests++; if (bus.seq_ready_o !== 1'b0) begin n_fail++; $display("FAIL strict_done_cycle: got ready %0d want 0", bus.seq_ready_o); end
    step();
    bus.ld_done_valid_i = 1'b0;
    settle();
    n_tests++; if (bus.seq_ready_o !== 1'b1 || bus.ld_cnt_o !== 4'd0) begin n_fail++; $display("FAIL strict_open: got ready %0d ld %0d want 1 0", bus.seq_ready_o, bus.ld_cnt_o); end
    step();
    bus.seq_valid_i = 1'b0;
    n_tests++; if (bus.pe_req_id_o !== 3'd1 || bus.pe_req_is_load_o !== 1'b0 || bus.pe_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL strict_store: got id %0d is_load %0d valid %0d want 1 0 1", bus.pe_req_id_o, bus.pe_req_is_load_o, bus.pe_req_valid_o); end
    n_tests++; if (bus.st_cnt_o !== 4'd1 || bus.ld_cnt_o !== 4'd0) begin n_fail++; $display("FAIL strict_cnt: got st %0d ld %0d want 1 0", bus.st_cnt_o, bus.ld_cnt_o); end
  endtask

  task automatic test_backpressure();
    logic [127:0] pa;
    logic [127:0] pb;
    pa = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
    pb = 128'hBBBB_7777_8888_9999_0000_1234_5678_9ABC;
    do_reset();
    bus.pe_req_ready_i = 1'b0;
    bus.seq_valid_i    = 1'b1;
    bus.seq_is_load_i  = 1'b1;
    bus.seq_payload_i  = pa;
    step();
    bus.seq_payload_i = pb;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_tests++; if (bus.seq_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %0d want 0", i, bus.seq_ready_o); end
      n_tests++; if (bus.pe_req_valid_o !== 1'b1 || bus.pe_req_id_o !== 3'd0 || bus.pe_req_payload_o !== pa) begin n_fail++; $display("FAIL bp_hold%0d: got valid %0d id %0d payload %h", i, bus.pe_req_valid_o, bus.pe_req_id_o, bus.pe_req_payload_o); end
      step();
    end
    bus.pe_req_ready_i = 1'b1;
    settle();
    n_tests++; if (bus.seq_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0d want 1", bus.seq_ready_o); end
    step();
    bus.seq_valid_i = 1'b0;
    n_tests++; if (bus.pe_req_id_o !== 3'd1 || bus.pe_req_payload_o !== pb || bus.ld_cnt_o !== 4'd2) begin n_fail++; $display("FAIL bp_next: got id %0d payload %h ld %0d want 1 pb 2", bus.pe_req_id_o, bus.pe_req_payload_o, bus.ld_cnt_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.seq_valid_i   = 1'b1;
    bus.seq_is_load_i = 1'b1;
    // Each new load also completes the previous one (except id 0), so ld_cnt settles at 2.
    for (int i = 0; i < 8; i++) begin
      bus.ld_done_valid_i = (i >= 2);
      bus.ld_done_id_i    = 3'(i - 1);
      settle();
      n_tests++; if (bus.seq_ready_o !== 1'b1) begin n_fail++; $display("FAIL wrap_ready%0d: got %0d want 1", i, bus.seq_ready_o); end
      step();
      n_tests++; if (bus.pe_req_id_o !== 3'(i) || bus.ld_cnt_o !== ((i == 0) ? 4'd1 : 4'd2)) begin n_fail++; $display("FAIL wrap_issue%0d: got id %0d ld %0d", i, bus.pe_req_id_o, bus.ld_cnt_o); end
    end
    bus.ld_done_valid_i = 1'b1;
    bus.ld_done_id_i    = 3'd7;
    settle();
    n_tests++; if (bus.seq_ready_o !== 1'b0) begin n_fail++; $display("FAIL wrap_stall: got ready %0d want 0", bus.seq_ready_o); end
    step();
    bus.ld_done_id_i = 3'd0;
    settle();
    n_tests++; if (bus.seq_ready_o !== 1'b0 || bus.ld_cnt_o !== 4'd1 || bus.pe_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL wrap_busy0: got ready %0d ld %0d valid %0d want 0 1 0", bus.seq_ready_o, bus.ld_cnt_o, bus.pe_req_valid_o); end
    step();
    bus.ld_done_valid_i = 1'b0;
    settle();
    n_tests++; if (bus.seq_ready_o !== 1'b1 || bus.ld_cnt_o !== 4'd0) begin n_fail++; $display("FAIL wrap_free0: got ready %0d ld %0d want 1 0", bus.seq_ready_o, bus.ld_cnt_o); end
    step();
    bus.seq_valid_i = 1'b0;
    n_tests++; if (bus.pe_req_valid_o !== 1'b1 || bus.pe_req_id_o !== 3'd0 || bus.ld_cnt_o !== 4'd1) begin n_fail++; $display("FAIL wrap_ninth: got valid %0d id %0d ld %0d want 1 0 1", bus.pe_req_valid_o, bus.pe_req_id_o, bus.ld_cnt_o); end
  endtask

  task automatic test_errors_reset();
    do_reset();
    bus.st_done_valid_i = 1'b1;
    bus.st_done_id_i    = 3'd3;
    step();
    bus.st_done_valid_i = 1'b0;
    n_tests++; if (bus.err_o !== 1'b1 || bus.st_cnt_o !== 4'd0 || bus.ld_cnt_o !== 4'd0) begin n_fail++; $display("FAIL err_idle_st: got err %0d st %0d ld %0d want 1 0 0", bus.err_o, bus.st_cnt_o, bus.ld_cnt_o); end
    step();
    n_tests++; if (bus.err_o !== 1'b1 || bus.idle_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got err %0d idle %0d want 1 1", bus.err_o, bus.idle_o); end
    bus.seq_valid_i   = 1'b1;
    bus.seq_is_load_i = 1'b1;
    step();
    step();
    n_tests++; if (bus.pe_req_valid_o !== 1'b1 || bus.ld_cnt_o !== 4'd2 || bus.err_o !== 1'b1) begin n_fail++; $display("FAIL burst_pre: got valid %0d ld %0d err %0d want 1 2 1", bus.pe_req_valid_o, bus.ld_cnt_o, bus.err_o); end
    rst = 1'b1;
    bus.seq_valid_i = 1'b0;
    settle();
    n_tests++; if (bus.pe_req_valid_o !== 1'b0 || bus.err_o !== 1'b0 || bus.idle_o !== 1'b1 || bus.ld_cnt_o !== 4'd0) begin n_fail++; $display("FAIL async_rst: got valid %0d err %0d idle %0d ld %0d want 0 0 1 0", bus.pe_req_valid_o, bus.err_o, bus.idle_o, bus.ld_cnt_o); end
    step();
    rst = 1'b0;
    bus.ld_done_valid_i = 1'b1;
    bus.ld_done_id_i    = 3'd0;
    step();
    bus.ld_done_valid_i = 1'b0;
    n_tests++; if (bus.err_o !== 1'b1 || bus.ld_cnt_o !== 4'd0) begin n_fail++; $display("FAIL late_done: got err %0d ld %0d want 1 0", bus.err_o, bus.ld_cnt_o); end
    do_reset();
    bus.seq_valid_i   = 1'b1;
    bus.seq_is_load_i = 1'b0;
    step();
    bus.seq_valid_i     = 1'b0;
    bus.ld_done_valid_i = 1'b1;
    bus.ld_done_id_i    = 3'd0;
    step();
    bus.ld_done_valid_i = 1'b0;
    n_tests++; if (bus.err_o !== 1'b1 || bus.st_cnt_o !== 4'd1) begin n_fail++; $display("FAIL type_mismatch: got err %0d st %0d want 1 1", bus.err_o, bus.st_cnt_o); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    quiet_inputs();
    test_reset();
    test_back_to_back();
    test_max_loads();
    test_strict_order();
    test_backpressure();
    test_wrap();
    test_errors_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
